// File: rtl/fetch_ctrl.sv
// Chronos instruction-fetch sequencer: owns the PC, runs a one-outstanding
// inst_mem handshake and feeds IF/ID from a small {pc,inst} queue.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] fetch_addr,
    output logic        fetch_req,
    input  logic        fetch_data_valid,
    input  logic [31:0] request_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        kill,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        tgt_q, tgt_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    entry_t             buf_q [BUF_DEPTH];
    logic               full, empty, push, pop;
    logic [31:0]        tgt_in;
    logic               unused_lsb;

    assign tgt_in     = {redirect_pc[31:2], 2'b00};
    assign unused_lsb = ^redirect_pc[1:0];
    assign full       = (cnt_q == CNT_W'(BUF_DEPTH));
    assign empty      = (cnt_q == '0);
    assign pop        = !empty && !stall && !redirect;

    // The PC only advances on an accepted response, so it doubles as the held request address.
    assign fetch_addr = pc_q;
    assign kill       = redirect && rst;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        fetch_req = 1'b0;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) pc_d = tgt_in;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = tgt_in;
                end else if (!full) begin
                    fetch_req = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                fetch_req = 1'b1;
                if (redirect) begin
                    if (fetch_data_valid) begin
                        pc_d    = tgt_in;
                        state_d = S_REQ;
                    end else begin
                        tgt_d   = tgt_in;
                        state_d = S_FLUSH;
                    end
                end else if (fetch_data_valid) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_FLUSH: begin
                // Keep the stale request alive until inst_mem answers, then drop it.
                fetch_req = 1'b1;
                if (fetch_data_valid) begin
                    pc_d    = redirect ? tgt_in : tgt_q;
                    state_d = S_REQ;
                end else if (redirect) begin
                    tgt_d = tgt_in;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        last_pc_d = last_pc_q;
        if (redirect) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop) begin
                rd_d      = rd_q + PTR_W'(1);
                last_pc_d = buf_q[rd_q].pc;
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            tgt_q     <= RESET_PC;
            last_pc_q <= RESET_PC;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            last_pc_q <= last_pc_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_q[wr_q] <= '{pc: pc_q, inst: request_data};
    end

    assign ifid_valid = !empty;
    assign ifid_inst  = empty ? NOP_INST  : buf_q[rd_q].inst;
    assign ifid_pc    = empty ? last_pc_q : buf_q[rd_q].pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (push)           perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall && !empty) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stalls  = 32'h0;
`endif
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the Chronos pipeline. Owns the PC, drives the one-outstanding request/valid handshake to inst_mem, and buffers fetched words in a 2-entry {pc,inst} queue feeding the IF/ID boundary. Honours HDU stalls and applies branch redirects with a kill pulse, discarding any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0013, word presented on ifid_inst when no valid entry (addi x0,x0,0)
BUF_DEPTH, 2, fetch queue entries (power of 2, >=2)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous active-low reset
fetch_addr  output  32  address to inst_mem, held stable while fetch_req high and unanswered
fetch_req  output  1  request valid to inst_mem
fetch_data_valid  input  1  inst_mem response valid
request_data  input  32  inst_mem response word
stall  input  1  HDU stall (inverse of PC_write); holds IF/ID output
redirect  input  1  branch/jump resolution: refetch from redirect_pc
redirect_pc  input  32  redirect target, bits [1:0] ignored (forced 0)
ifid_inst  output  32  instruction to decode
ifid_pc  output  32  PC of ifid_inst
ifid_valid  output  1  ifid_inst is real (not bubble)
kill  output  1  one-cycle pulse: younger instructions squashed
perf_fetched  output  32  fetched-word counter (optional feature)
perf_stalls  output  32  stall-cycle counter (optional feature)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, queue empty, fetch_req=0, fetch_addr=RESET_PC, ifid_valid=0, ifid_inst=NOP_INST, ifid_pc=RESET_PC, kill=0, counters 0.
- States: IDLE -> REQ (unconditionally, first cycle after reset release). REQ: fetch_req=1, fetch_addr=pc, only if occupancy < BUF_DEPTH; else stay REQ with fetch_req=0. REQ -> WAIT once request issued. WAIT: fetch_req held 1, fetch_addr held; on fetch_data_valid push {pc,request_data}, pc+=4 (32-bit wrap at 32'hFFFF_FFFC -> 0), -> REQ. FLUSH: fetch_req held 1 at old address; on fetch_data_valid drop data, pc=saved target, -> REQ.
- Response accepted same cycle it arrives; min latency req->push 1 cycle; throughput 1 word per 2 cycles minimum.
- fetch_data_valid outside WAIT/FLUSH ignored.
- Queue output: ifid_* = head entry, ifid_valid=1 when non-empty; empty -> ifid_inst=NOP_INST, ifid_valid=0, ifid_pc=last popped pc. Pop when ifid_valid && !stall. Push and pop same cycle legal when not full (occupancy unchanged). Full: no new request issued.
- stall: freezes queue head and pop only; fetching continues until full.
- redirect (priority over stall and over a same-cycle push): queue flushed, kill=1 for exactly that cycle, ifid_valid=0 next cycle. In REQ/IDLE: pc=redirect_pc&~3, stay REQ. In WAIT: save target, -> FLUSH. In FLUSH: overwrite saved target. Redirect coincident with fetch_data_valid in WAIT: response dropped, pc=target, -> REQ.
- Reset mid-WAIT: abandons request; inst_mem must also be reset by same rst.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, perf_fetched increments on each queue push, perf_stalls on each cycle stall=1 && ifid_valid=1; both wrap at 2^32, cleared by reset only. When undefined, both outputs tied to 32'h0 and no counter flops exist.

Test Plan:
- Reset release, mem latency 1, no stall -> fetch_addr 0x0,0x4,0x8 on successive requests; ifid_pc 0x0 then 0x4 with matching words; ifid_valid=0 before first push.
- stall held 6 cycles from first valid, latency 1 -> exactly 2 words queued, fetch_req low while full; release -> pops 0x0, 0x4 in order, fetch resumes at 0x8.
- redirect to 0x100 while WAIT at 0x8 (latency 3) -> kill 1 cycle, 0x8 response dropped, next fetch_addr 0x100, next ifid_pc 0x100.
- redirect to 0x203 same cycle as fetch_data_valid -> response dropped, fetch_addr 0x200, no stale entry reaches ifid.
- pc=0xFFFF_FFFC fetch -> next fetch_addr 0x0000_0000.
- With FETCH_PERF_CNT_EN, 10 fetches and 4 stalled-valid cycles -> perf_fetched=10, perf_stalls=4; without macro both read 0.
